// File: rtl/frogger_motion_ctrl_if.sv
// Control strobes from the frame/game logic and object origins/time bar
// to the colour-code renderer for the Frogger motion controller.
interface frogger_motion_ctrl_if;
  logic       frame_clk;
  logic       start;
  logic       restart;
  logic       pause;
  logic [9:0] firetruckX;
  logic [9:0] busX;
  logic [9:0] motorcycleX;
  logic [9:0] shortlogX;
  logic [9:0] mediumlogX;
  logic [9:0] longlogX;
  logic [9:0] time_width;
  logic       time_up;
  logic       running;

  // driver of frame/game controls, consumer of positions
  modport master (
    output frame_clk, start, restart, pause,
    input  firetruckX, busX, motorcycleX, shortlogX, mediumlogX, longlogX,
    input  time_width, time_up, running
  );

  // the motion controller itself
  modport slave (
    input  frame_clk, start, restart, pause,
    output firetruckX, busX, motorcycleX, shortlogX, mediumlogX, longlogX,
    output time_width, time_up, running
  );
endinterface

// File: rtl/frogger_motion_ctrl.sv
// Per-frame motion and time-bar controller: moves three vehicles and three
// logs once per video frame with horizontal wrap, and counts the time bar
// down every TIME_DIV frames. All outputs are registered.
module frogger_motion_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int TRUCK_SPEED = 2,
  parameter int BUS_SPEED   = 1,
  parameter int MOTO_SPEED  = 3,
  parameter int LOG_SPEED   = 1,
  parameter int TIME_MAX    = 200,
  parameter int TIME_DIV    = 30
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  frogger_motion_ctrl_if.slave io
);

  localparam int CW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  localparam logic [10:0] W11     = 11'(SCREEN_W);
  localparam logic [10:0] S_TRUCK = 11'(TRUCK_SPEED);
  localparam logic [10:0] S_BUS   = 11'(BUS_SPEED);
  localparam logic [10:0] S_MOTO  = 11'(MOTO_SPEED);
  localparam logic [10:0] S_LOG   = 11'(LOG_SPEED);
  localparam logic [9:0]  T_MAX   = 10'(TIME_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIME_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, TIMEOUT} state_t;

  state_t        state;
  logic          frame_s;   // frame_clk sampled once
  logic          frame_d;   // previous sample, for edge detect
  logic          armed;     // frame_clk seen low since reset
  logic [CW-1:0] frame_cnt;
  logic [9:0]    truck_x, bus_x, moto_x, slog_x, mlog_x, llog_x;
  logic [9:0]    time_w;
  logic          time_up_r, running_r;
  logic          tick;

  // Edge detect on the sampled level so new positions land one edge after
  // frame_clk is first seen high. A level still high when reset releases
  // is not an edge: armed waits for a low sample first.
  assign tick = frame_s & ~frame_d & armed;

  function automatic logic [9:0] mv_left(input logic [9:0] x, input logic [10:0] s);
    logic [10:0] t;
    if ({1'b0, x} >= s) t = {1'b0, x} - s;
    else                t = {1'b0, x} + W11 - s;
    return t[9:0];
  endfunction

  function automatic logic [9:0] mv_right(input logic [9:0] x, input logic [10:0] s);
    logic [10:0] t;
    t = {1'b0, x} + s;
    if (t >= W11) t = t - W11;
    return t[9:0];
  endfunction

  // Game state, frame edge detect, positions and timer
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      frame_s   <= 1'b0;
      frame_d   <= 1'b0;
      armed     <= 1'b0;
      frame_cnt <= '0;
      truck_x   <= 10'd440;
      bus_x     <= 10'd440;
      moto_x    <= 10'd440;
      slog_x    <= 10'd0;
      mlog_x    <= 10'd200;
      llog_x    <= 10'd400;
      time_w    <= T_MAX;
      time_up_r <= 1'b0;
      running_r <= 1'b0;
    end else begin
      frame_s <= io.frame_clk;
      frame_d <= frame_s;
      if (!io.frame_clk) armed <= 1'b1;

      if (io.restart) begin
        // reload wins over any tick in the same cycle; positions are kept
        state     <= RUN;
        time_w    <= T_MAX;
        frame_cnt <= '0;
        time_up_r <= 1'b0;
        running_r <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (io.start) begin
              state     <= RUN;
              running_r <= 1'b1;
            end
          end
          RUN: begin
            if (tick && !io.pause) begin
              truck_x <= mv_left (truck_x, S_TRUCK);
              bus_x   <= mv_right(bus_x,   S_BUS);
              moto_x  <= mv_left (moto_x,  S_MOTO);
              slog_x  <= mv_right(slog_x,  S_LOG);
              mlog_x  <= mv_right(mlog_x,  S_LOG);
              llog_x  <= mv_right(llog_x,  S_LOG);
              if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                time_w    <= time_w - 10'd1;
                if (time_w == 10'd1) begin
                  state     <= TIMEOUT;
                  time_up_r <= 1'b1;
                  running_r <= 1'b0;
                end
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
          TIMEOUT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io.firetruckX  = truck_x;
  assign io.busX        = bus_x;
  assign io.motorcycleX = moto_x;
  assign io.shortlogX   = slog_x;
  assign io.mediumlogX  = mlog_x;
  assign io.longlogX    = llog_x;
  assign io.time_width  = time_w;
  assign io.time_up     = time_up_r;
  assign io.running     = running_r;

endmodule

// File: tb/tb_frogger_motion_ctrl.sv
// Scoreboard bench for frogger_motion_ctrl: an independent model predicts
// outputs per stimulus step, expectations are queued and compared once the
// DUT has had time to respond.
module tb_frogger_motion_ctrl;
  logic Clk = 1'b0;
  logic Reset_n;

  frogger_motion_ctrl_if io();

  frogger_motion_ctrl dut (.Clk(Clk), .Reset_n(Reset_n), .io(io));

  always #5 Clk = ~Clk;

  typedef struct {
    int ft, bus, moto, sl, ml, ll, tw, tu, run;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  // model state: 0 idle, 1 run, 2 timeout
  int m_st, m_ft, m_bus, m_moto, m_sl, m_ml, m_ll, m_tw, m_cnt;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ft = 440; m_bus = 440; m_moto = 440;
    m_sl = 0; m_ml = 200; m_ll = 400; m_tw = 200; m_cnt = 0;
  endtask

  function automatic int lft(input int x, input int s);
    return (x + 640 - s) % 640;
  endfunction

  function automatic int rgt(input int x, input int s);
    return (x + s) % 640;
  endfunction

  task automatic model_tick(input bit rs, input bit pz);
    if (rs) begin
      m_st = 1; m_tw = 200; m_cnt = 0;
    end else if (m_st == 1 && !pz) begin
      m_ft = lft(m_ft, 2); m_bus = rgt(m_bus, 1); m_moto = lft(m_moto, 3);
      m_sl = rgt(m_sl, 1); m_ml = rgt(m_ml, 1);   m_ll = rgt(m_ll, 1);
      m_cnt++;
      if (m_cnt == 30) begin
        m_cnt = 0;
        m_tw--;
        if (m_tw == 0) m_st = 2;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ft = m_ft; e.bus = m_bus; e.moto = m_moto;
    e.sl = m_sl; e.ml = m_ml;   e.ll = m_ll;
    e.tw = m_tw; e.tu = (m_st == 2) ? 1 : 0; e.run = (m_st == 1) ? 1 : 0;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, ".sb_empty"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".firetruckX"},  int'(io.firetruckX),  e.ft);
      chk({tag, ".busX"},        int'(io.busX),        e.bus);
      chk({tag, ".motorcycleX"}, int'(io.motorcycleX), e.moto);
      chk({tag, ".shortlogX"},   int'(io.shortlogX),   e.sl);
      chk({tag, ".mediumlogX"},  int'(io.mediumlogX),  e.ml);
      chk({tag, ".longlogX"},    int'(io.longlogX),    e.ll);
      chk({tag, ".time_width"},  int'(io.time_width),  e.tw);
      chk({tag, ".time_up"},     int'(io.time_up),     e.tu);
      chk({tag, ".running"},     int'(io.running),     e.run);
    end
  endtask

  // one frame: frame_clk high for 2+hold cycles, optional restart on the
  // edge where the tick takes effect
  task automatic tick(input string tag, input bit rs, input int hold);
    model_tick(rs, io.pause);
    push_exp();
    @(negedge Clk) io.frame_clk = 1'b1;
    @(negedge Clk) io.restart = rs;
    @(negedge Clk) io.restart = 1'b0;
    repeat (hold) @(negedge Clk);
    io.frame_clk = 1'b0;
    @(negedge Clk);
    pop_cmp(tag);
  endtask

  task automatic start_pulse(input string tag);
    if (m_st == 0) m_st = 1;
    push_exp();
    @(negedge Clk) io.start = 1'b1;
    @(negedge Clk) io.start = 1'b0;
    pop_cmp(tag);
  endtask

  task automatic restart_pulse(input string tag);
    model_tick(1'b1, 1'b0);
    push_exp();
    @(negedge Clk) io.restart = 1'b1;
    @(negedge Clk) io.restart = 1'b0;
    pop_cmp(tag);
  endtask

  initial begin
    int guard;
    Reset_n = 1'b0;
    io.frame_clk = 1'b0; io.start = 1'b0; io.restart = 1'b0; io.pause = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    push_exp();
    pop_cmp("reset");
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // IDLE ignores frames
    tick("idle_tick", 1'b0, 0);

    // first motion frame
    start_pulse("start");
    tick("first_tick", 1'b0, 0);

    // pause discards ticks
    io.pause = 1'b1;
    for (int i = 0; i < 5; i++) tick("pause_tick", 1'b0, 0);
    io.pause = 1'b0;

    // restart wins over a coincident tick
    tick("restart_tick", 1'b1, 0);

    // long-held frame level still gives a single update
    tick("long_high", 1'b0, 10);

    // start while running is ignored
    start_pulse("start_in_run");

    // run the timer out from a fresh reload; wraps happen along the way
    restart_pulse("reload");
    guard = 0;
    while (m_st == 1 && guard < 7000) begin
      tick("run", 1'b0, 0);
      guard++;
    end
    chk("timeout_reached", int'(io.time_up), 1);

    // frozen in TIMEOUT, start ignored
    tick("frozen", 1'b0, 0);
    tick("frozen", 1'b0, 0);
    start_pulse("start_in_timeout");

    restart_pulse("restart_after_timeout");
    tick("after_restart", 1'b0, 0);

    // async reset while frame_clk is high, release with level still high
    @(negedge Clk) io.frame_clk = 1'b1;
    @(negedge Clk) Reset_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    pop_cmp("rst_async");
    @(negedge Clk) begin Reset_n = 1'b1; io.start = 1'b1; end
    @(negedge Clk) io.start = 1'b0;
    m_st = 1;
    repeat (3) @(negedge Clk);
    push_exp();
    pop_cmp("release_high");
    @(negedge Clk) io.frame_clk = 1'b0;
    @(negedge Clk);
    tick("fresh_edge", 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
